run_sequencer: RTL and testbench
================================

# run_sequencer

Program-control sequencer for the 9-bit core. It owns the program counter and the start/done handshake with the testbench, and generates the `run` enable that gates register-file and data-memory writes. It sits between the top level and the instruction memory, replacing the fixed PC and the free-running PC mux. It is a parametrised successor to the single-cycle PC path, adding stall support, absolute jumps, a clear phase, a cycle counter and an optional PC-overflow trap.

## Interface
Parameters:
- `PC_W`, 10, program-counter width; instruction memory depth is 2^PC_W.
- `OFFSET_W`, 8, width of the signed branch offset; must satisfy `OFFSET_W` <= `PC_W`.
- `START_PC`, 0, PC value loaded when a run is armed.
- `CNT_W`, 16, width of the cycle counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: testbench start; high = arm/hold, falling = begin run.
- `halt` in 1: current instruction is the halt/done instruction (from the decoder).
- `stall` in 1: current instruction needs another cycle; PC holds.
- `jump_en` in 1: absolute jump to `jump_target`.
- `jump_target` in PC_W: absolute jump address.
- `branch_taken` in 1: relative branch taken (branch_en & zero).
- `offset` in OFFSET_W: two's-complement branch offset.
- `pc` out PC_W: address presented to instruction memory.
- `run` out 1: core enable; writes are permitted only while high.
- `clear` out 1: high during ARMED; synchronous clear for the register file.
- `done` out 1: program finished.
- `err` out 1: PC-overflow trap flag (see Configuration).
- `cycle_count` out CNT_W: number of RUN cycles in the last or current run.

## Operation
States: IDLE, ARMED, RUN, DONE, with 2-bit encoding.
- Reset (`reset`=0, asynchronous): state=IDLE, `pc`=START_PC, `cycle_count`=0, `done`=0, `run`=0, `clear`=0, `err`=0.
- IDLE: if `start`=1, go to ARMED, load `pc`<=START_PC, clear `cycle_count` and `err`.
- ARMED: `clear`=1, `run`=0. Stays in ARMED while `start`=1; `start`=0 moves to RUN.
- RUN: `run`=1. The next PC is chosen by priority:
  1. `stall`: hold `pc`.
  2. `halt`: go to DONE and hold `pc`.
  3. `jump_en`: `pc`<=`jump_target`.
  4. `branch_taken`: `pc`<=`pc`+1+sext(`offset`).
  5. Otherwise: `pc`<=`pc`+1.
- RUN arithmetic: all PC arithmetic is modulo 2^PC_W. `offset` is sign-extended to PC_W.
- RUN counter: `cycle_count` increments on every RUN cycle, including stall cycles and the halt cycle, and saturates at 2^CNT_W-1.
- RUN restart: `start`=1 while in RUN goes to ARMED (restart), overriding every other input.
- DONE: `done`=1, `run`=0, and `pc` and `cycle_count` are frozen. `start`=1 goes to ARMED; `done` falls on that same edge.
- Inputs other than `start` are ignored outside RUN.

## Timing
- All outputs are registered; there are no combinational paths from input to output.
- `pc` updates on the rising edge following the cycle in which the instruction was decoded. The fetch-to-next-fetch latency is 1 cycle, or 1+N cycles with N stall cycles.
- The first RUN cycle presents `pc`=START_PC. `run` rises on the edge where `start` is sampled low in ARMED.
- `done` rises on the edge after `halt` is sampled with `stall`=0, and stays high until the next `start`.
- Reset asserted mid-run aborts immediately and asynchronously. Deassertion is synchronised by the top level.

## Configuration
- Macro `RUN_SEQ_PC_TRAP_EN`.
- With the macro defined:
  - In RUN, a sequential or branch update whose true (unwrapped) target is outside 0..2^PC_W-1 goes to DONE with `err`=1 and `pc` unchanged.
  - Jumps are always in range and never trap.
  - `err` clears on ARMED entry.
- Without the macro: the PC wraps silently and `err` is tied 0.

## Test plan
- Reset then `start` 1→0, with no branch/jump/stall/halt for 5 cycles: `pc` runs 0,1,2,3,4 and `run`=1. Then `halt`=1 at `pc`=4: `done`=1 next edge, `pc` stays 4, `cycle_count`=5.
- Branch: at `pc`=10 with `branch_taken`=1, `offset`=8'hFB (−5): next `pc`=6. At `pc`=6 with `offset`=8'h04: next `pc`=11.
- Priority: at `pc`=20, drive `stall`=1 with `halt`=1 and `jump_en`=1 for 2 cycles, then `stall`=0 with `halt`=1: `pc` holds at 20, `done` rises after the third cycle, and `cycle_count` grows by 3.
- Wrap/trap with PC_W=10: at `pc`=1023, sequential step → `pc`=0 and `err`=0 without the macro; DONE with `err`=1 and `pc`=1023 with the macro.
- Restart and reset:
  - `start`=1 mid-RUN: next cycle `run`=0 and `clear`=1; after `start`=0, `pc` restarts at START_PC.
  - `reset`=0 mid-RUN: all outputs return to reset values without waiting for a clock edge.
- `cycle_count` saturation with CNT_W=4: 20 RUN cycles → `cycle_count`=15.

Source files
------------

// File: rtl/run_sequencer.sv
// Program-control sequencer: owns the PC, the start/done handshake and the run/clear enables.
// Optional PC-overflow trap is enabled by defining RUN_SEQ_PC_TRAP_EN.
module run_sequencer #(
    parameter int PC_W     = 10,
    parameter int OFFSET_W = 8,
    parameter int START_PC = 0,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                halt,
    input  logic                stall,
    input  logic                jump_en,
    input  logic [PC_W-1:0]     jump_target,
    input  logic                branch_taken,
    input  logic [OFFSET_W-1:0] offset,
    output logic [PC_W-1:0]     pc,
    output logic                run,
    output logic                clear,
    output logic                done,
    output logic                err,
    output logic [CNT_W-1:0]    cycle_count,
    output logic [1:0]          state_dbg
);

    // Handshake: start high arms (and holds) the core; the run begins on the edge
    // where start is sampled low in ARMED. done stays high until start is seen again.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [PC_W-1:0] START = PC_W'(START_PC);

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;

    logic [PC_W-1:0]   off_ext;
    logic [PC_W-1:0]   pc_seq;
    logic [PC_W-1:0]   pc_br;
    logic              seq_trap;
    logic              br_trap;

    assign off_ext = PC_W'($signed(offset));
    assign pc_seq  = pc_q + PC_W'(1);
    assign pc_br   = pc_q + PC_W'(1) + off_ext;

`ifdef RUN_SEQ_PC_TRAP_EN
    // Two guard bits keep the true branch target: sign bit set means below 0,
    // bit PC_W set means past the top of instruction memory.
    logic signed [PC_W+1:0] br_wide;
    assign br_wide  = $signed({2'b00, pc_q}) + (PC_W+2)'(1) + (PC_W+2)'($signed(offset));
    assign br_trap  = br_wide[PC_W+1] | br_wide[PC_W];
    assign seq_trap = &pc_q;
`else
    assign br_trap  = 1'b0;
    assign seq_trap = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pc_q    <= START;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_ARMED;
                    pc_d    = START;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            S_ARMED: begin
                pc_d = START;
                if (!start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (start) begin
                    // Restart wins over every decoder input.
                    state_d = S_ARMED;
                    pc_d    = START;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end else begin
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (stall) begin
                        pc_d = pc_q;
                    end else if (halt) begin
                        state_d = S_DONE;
                    end else if (jump_en) begin
                        pc_d = jump_target;
                    end else if (branch_taken) begin
                        if (br_trap) begin
                            state_d = S_DONE;
                            err_d   = 1'b1;
                        end else begin
                            pc_d = pc_br;
                        end
                    end else begin
                        if (seq_trap) begin
                            state_d = S_DONE;
                            err_d   = 1'b1;
                        end else begin
                            pc_d = pc_seq;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decode registered state only, so nothing combinational reaches a port.
    assign pc          = pc_q;
    assign cycle_count = cnt_q;
    assign run         = (state_q == S_RUN);
    assign clear       = (state_q == S_ARMED);
    assign done        = (state_q == S_DONE);
    assign err         = err_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Bench for run_sequencer: integer-arithmetic reference model checked every cycle,
// plus literal expectations from the directed scenarios. Honours RUN_SEQ_PC_TRAP_EN.
module tb_run_sequencer;

    localparam int PC_W     = 10;
    localparam int OFFSET_W = 8;
    localparam int START_PC = 0;
    localparam int CNT_W    = 4;
    localparam int PC_MOD   = 1 << PC_W;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;
`ifdef RUN_SEQ_PC_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    localparam int M_IDLE  = 0;
    localparam int M_ARMED = 1;
    localparam int M_RUN   = 2;
    localparam int M_DONE  = 3;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                start = 1'b0;
    logic                halt = 1'b0;
    logic                stall = 1'b0;
    logic                jump_en = 1'b0;
    logic [PC_W-1:0]     jump_target = '0;
    logic                branch_taken = 1'b0;
    logic [OFFSET_W-1:0] offset = '0;
    logic [PC_W-1:0]     pc;
    logic                run;
    logic                clear;
    logic                done;
    logic                err;
    logic [CNT_W-1:0]    cycle_count;
    logic [1:0]          state_dbg;

    int checks = 0;
    int errors = 0;

    run_sequencer #(
        .PC_W(PC_W), .OFFSET_W(OFFSET_W), .START_PC(START_PC), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .halt(halt), .stall(stall),
        .jump_en(jump_en), .jump_target(jump_target), .branch_taken(branch_taken),
        .offset(offset), .pc(pc), .run(run), .clear(clear), .done(done), .err(err),
        .cycle_count(cycle_count), .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_mode = M_IDLE;
    int m_pc   = START_PC;
    int m_cnt  = 0;
    bit m_err  = 1'b0;

    task automatic model_arm();
        m_mode = M_ARMED;
        m_pc   = START_PC;
        m_cnt  = 0;
        m_err  = 1'b0;
    endtask

    task automatic model_step();
        int off_i;
        int tgt;
        off_i = $signed(offset);
        if (m_mode == M_IDLE || m_mode == M_DONE) begin
            if (start) model_arm();
        end else if (m_mode == M_ARMED) begin
            if (!start) m_mode = M_RUN;
        end else begin
            if (start) begin
                model_arm();
            end else begin
                m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
                if (stall) begin
                    // pc holds
                end else if (halt) begin
                    m_mode = M_DONE;
                end else if (jump_en) begin
                    m_pc = int'(jump_target);
                end else begin
                    tgt = m_pc + 1 + (branch_taken ? off_i : 0);
                    if (tgt >= 0 && tgt < PC_MOD) begin
                        m_pc = tgt;
                    end else if (TRAP) begin
                        m_mode = M_DONE;
                        m_err  = 1'b1;
                    end else begin
                        m_pc = (tgt + PC_MOD) % PC_MOD;
                    end
                end
            end
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_mode = M_IDLE;
            m_pc   = START_PC;
            m_cnt  = 0;
            m_err  = 1'b0;
        end else begin
            model_step();
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        chk("pc", 32'(pc), 32'(m_pc));
        chk("run", 32'(run), 32'(m_mode == M_RUN));
        chk("clear", 32'(clear), 32'(m_mode == M_ARMED));
        chk("done", 32'(done), 32'(m_mode == M_DONE));
        chk("err", 32'(err), 32'(m_err));
        chk("cycle_count", 32'(cycle_count), 32'(m_cnt));
    end

    // ---------------- driver tasks ----------------
    task automatic step(input bit s, input bit h, input bit st, input bit j,
                        input int jt, input bit b, input int off);
        start        = s;
        halt         = h;
        stall        = st;
        jump_en      = j;
        jump_target  = PC_W'(jt);
        branch_taken = b;
        offset       = OFFSET_W'(off);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_step();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic arm_and_run();
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        #1 reset = 1'b0;
        #1;
        chk("rst_pc", 32'(pc), 32'(START_PC));
        chk("rst_run", 32'(run), 0);
        chk("rst_clear", 32'(clear), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_cnt", 32'(cycle_count), 0);
        #10 reset = 1'b1;
        @(posedge clk);
        #1;

        // basic sequential run then halt at pc 4
        step(1, 0, 0, 0, 0, 0, 0);
        chk("armed_clear", 32'(clear), 1);
        chk("armed_run", 32'(run), 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("run_first_pc", 32'(pc), 0);
        chk("run_high", 32'(run), 1);
        for (int i = 1; i <= 4; i++) begin
            idle_step();
            chk("seq_pc", 32'(pc), 32'(i));
        end
        step(0, 1, 0, 0, 0, 0, 0);
        chk("halt_done", 32'(done), 1);
        chk("halt_pc", 32'(pc), 4);
        chk("halt_cnt", 32'(cycle_count), 5);
        chk("halt_run", 32'(run), 0);

        // branches from pc 10
        arm_and_run();
        chk("restart_done_low", 32'(done), 0);
        step(0, 0, 0, 1, 10, 0, 0);
        chk("jump_pc", 32'(pc), 10);
        step(0, 0, 0, 0, 0, 1, 8'hFB);
        chk("branch_back_pc", 32'(pc), 6);
        step(0, 0, 0, 0, 0, 1, 8'h04);
        chk("branch_fwd_pc", 32'(pc), 11);

        // priority: stall beats halt and jump
        arm_and_run();
        step(0, 0, 0, 1, 20, 0, 0);
        step(0, 1, 1, 1, 100, 0, 0);
        step(0, 1, 1, 1, 100, 0, 0);
        chk("stall_pc", 32'(pc), 20);
        chk("stall_done", 32'(done), 0);
        step(0, 1, 0, 1, 100, 0, 0);
        chk("prio_done", 32'(done), 1);
        chk("prio_pc", 32'(pc), 20);
        chk("prio_cnt", 32'(cycle_count), 4);

        // wrap / trap at the top of memory
        arm_and_run();
        step(0, 0, 0, 1, 1023, 0, 0);
        idle_step();
        chk("wrap_pc", 32'(pc), TRAP ? 1023 : 0);
        chk("wrap_err", 32'(err), 32'(TRAP));
        chk("wrap_done", 32'(done), 32'(TRAP));
        arm_and_run();
        chk("err_cleared", 32'(err), 0);
        step(0, 0, 0, 0, 0, 1, 8'hFB);
        chk("neg_wrap_pc", 32'(pc), TRAP ? 0 : 1020);
        chk("neg_wrap_err", 32'(err), 32'(TRAP));
        arm_and_run();
        step(0, 0, 0, 1, 1020, 0, 0);
        step(0, 0, 0, 0, 0, 1, 8'h05);
        chk("fwd_wrap_pc", 32'(pc), TRAP ? 1020 : 2);

        // restart mid-run
        arm_and_run();
        idle_step();
        idle_step();
        idle_step();
        step(1, 0, 0, 1, 50, 1, 3);
        chk("restart_run", 32'(run), 0);
        chk("restart_clear", 32'(clear), 1);
        chk("restart_pc", 32'(pc), START_PC);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("restart_run_pc", 32'(pc), START_PC);
        idle_step();
        chk("restart_next_pc", 32'(pc), START_PC + 1);

        // counter saturation
        arm_and_run();
        for (int i = 0; i < 20; i++) idle_step();
        chk("sat_cnt", 32'(cycle_count), 15);
        chk("sat_pc", 32'(pc), 20);

        // randomized mix, checked by the model every cycle
        for (int i = 0; i < 300; i++) begin
            step((m_mode == M_DONE) || ($urandom_range(0, 29) == 0),
                 $urandom_range(0, 11) == 0,
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 9) == 0,
                 int'($urandom_range(0, PC_MOD - 1)),
                 $urandom_range(0, 3) == 0,
                 int'($urandom_range(0, 255)));
        end

        // asynchronous reset mid-run
        arm_and_run();
        step(0, 0, 0, 1, 300, 0, 0);
        idle_step();
        #2 reset = 1'b0;
        #1;
        chk("async_pc", 32'(pc), START_PC);
        chk("async_run", 32'(run), 0);
        chk("async_clear", 32'(clear), 0);
        chk("async_done", 32'(done), 0);
        chk("async_err", 32'(err), 0);
        chk("async_cnt", 32'(cycle_count), 0);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        idle_step();
        chk("post_reset_idle_run", 32'(run), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
